// File: rtl/ifm_stream_reader_if.sv
// ifm_stream_reader_if
//   Word stream from the IFM reader to the compute datapath. This is a valid/ready handshake:
//   a word moves across in a cycle where out_valid and out_ready are both high.
//   Signals:
//     out_valid  source -> sink  out_data holds a word
//     out_data   source -> sink  streamed word
//     out_last   source -> sink  marks the final word of a burst
//     out_ready  sink -> source  sink accepts the word
//   Modports: master = the streaming source (the reader), slave = the consumer.
interface ifm_stream_reader_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_ready;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/ifm_stream_reader.sv
// ifm_stream_reader
//   Reads a contiguous burst of words from a synchronous-read memory with a 1-cycle read
//   latency. It streams those words to a consumer over a valid/ready handshake.
//   A 2-entry output FIFO hides the read latency, so the block sustains 1 word/cycle
//   under arbitrary backpressure.
//   Ports:
//     clk, rst     clock; synchronous active-high reset
//     start        burst request, taken only while idle
//     base_addr    first word address (latched on start)
//     length       word count 0..DEPTH (latched on start)
//     busy         burst in progress
//     done         one-cycle pulse after the final word has been accepted
//     mem_rd_en    memory read strobe
//     mem_addr     memory read address
//     mem_rd_data  read data, valid the cycle after mem_rd_en
//     ifm          output word stream (master side)
module ifm_stream_reader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    length,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_rd_data,
    ifm_stream_reader_if.master  ifm
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    // DEPTH must divide 2**ADDR_W (and be smaller than it). That way the ADDR_W-bit
    // wrapping sum of base and offset, reduced modulo DEPTH, gives the true modulo address.
    localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   len_q;
    logic [ADDR_W-1:0]   issued_q;
    logic [ADDR_W-1:0]   accepted_q;
    logic                inflight_q;
    logic [DATA_W-1:0]   fifo_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;

    logic                start_acc;
    logic                push;
    logic                pop;
    logic                last_word;
    logic                fifo_valid;
    logic [1:0]          slots_used;
    logic [ADDR_W-1:0]   addr_raw;

    // Control FSM
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = (length == '0) ? StFin : StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (pop && last_word) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Read issue and output stream
    always_comb begin
        fifo_valid = (count_q != 2'd0);
        pop        = fifo_valid && ifm.out_ready;
        push       = inflight_q;
        last_word  = (accepted_q == len_q - ADDR_W'(1));
        // A same-cycle pop frees its slot right away. Without that credit, a 2-deep
        // buffer could not keep one word per cycle moving.
        slots_used = count_q + {1'b0, inflight_q} - {1'b0, pop};
        mem_rd_en  = (state_q == StRun) && (issued_q < len_q) && (slots_used < 2'd2);
        addr_raw   = base_q + issued_q;
        mem_addr   = mem_rd_en ? (addr_raw % DepthA) : '0;
    end

    assign ifm.out_valid = fifo_valid;
    assign ifm.out_data  = fifo_valid ? fifo_q[rd_ptr_q] : '0;
    assign ifm.out_last  = fifo_valid && last_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            inflight_q <= mem_rd_en;
            if (start_acc) begin
                base_q     <= base_addr;
                len_q      <= length;
                issued_q   <= '0;
                accepted_q <= '0;
            end else begin
                issued_q   <= issued_q + ADDR_W'(mem_rd_en);
                accepted_q <= accepted_q + ADDR_W'(pop);
            end
            // Returned data is only captured in the cycle after a read strobe.
            if (push) begin
                fifo_q[wr_ptr_q] <= mem_rd_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
